// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V style controller: Moore FSM sequencing fetch/decode/execute,
// plus a retired-instruction counter. Memory wait states are added by MULTICYCLE_CTRL_MEMWAIT_EN.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
  input  logic        memReady,
`endif
  input  logic [6:0]  op,
  input  logic        zero,
  output logic        pcWrite,
  output logic        adrSrc,
  output logic        memWrite,
  output logic        irWrite,
  output logic        regWrite,
  output logic [1:0]  resultSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic [1:0]  immSrc,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BEQ
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        ready;
  logic        pcUpdate, branch, retire, unknownOp;
  logic        irWriteRaw, memWriteRaw, regWriteRaw;

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
  assign ready = memReady;
`else
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = FETCH;
    unknownOp = 1'b0;
    case (state_q)
      FETCH:    state_d = ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECR;
          OP_I:         state_d = EXECI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          default: begin
            state_d   = FETCH;
            unknownOp = 1'b1;
          end
        endcase
      end
      MEMADR:   state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = ready ? MEMWB : MEMREAD;
      MEMWRITE: state_d = ready ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  // A store retires only on the edge that actually leaves MEMWRITE.
  assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BEQ) ||
                  ((state_q == MEMWRITE) && ready);
  assign instret_d = retire ? instret_q + 32'd1 : instret_q;

  always_comb begin
    irWriteRaw  = 1'b0;
    memWriteRaw = 1'b0;
    regWriteRaw = 1'b0;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    adrSrc      = 1'b0;
    resultSrc   = 2'b00;
    aluSrcA     = 2'b00;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    case (state_q)
      FETCH: begin
        irWriteRaw = ready;
        pcUpdate   = ready;
        aluSrcB    = 2'b10;
        resultSrc  = 2'b10;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
      end
      MEMADR: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      MEMREAD:  adrSrc = 1'b1;
      MEMWB: begin
        resultSrc   = 2'b01;
        regWriteRaw = 1'b1;
      end
      MEMWRITE: begin
        adrSrc      = 1'b1;
        memWriteRaw = 1'b1;
      end
      EXECR: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b10;
      end
      EXECI: begin
        aluSrcA = 2'b10;
        aluSrcB = 2'b01;
      end
      ALUWB:    regWriteRaw = 1'b1;
      JAL: begin
        aluSrcA  = 2'b01;
        aluSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      BEQ: begin
        aluSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Write enables are suppressed while reset is held so nothing is corrupted mid-instruction.
  assign pcWrite  = !reset && (pcUpdate || (branch && zero));
  assign irWrite  = !reset && irWriteRaw;
  assign memWrite = !reset && memWriteRaw;
  assign regWrite = !reset && regWriteRaw;
  assign illegal  = !reset && (state_q == DECODE) && unknownOp;

  always_comb begin
    case (op)
      OP_SW:   immSrc = 2'b01;
      OP_BEQ:  immSrc = 2'b10;
      OP_JAL:  immSrc = 2'b11;
      default: immSrc = 2'b00;
    endcase
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; also covers the
// MULTICYCLE_CTRL_MEMWAIT_EN build when that macro is defined.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic        zero;
  logic        pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0]  resultSrc, aluSrcA, aluSrcB, aluOp, immSrc;
  logic [31:0] instret;
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
  logic        memReady = 1'b1;
`endif

  int total = 0;
  int bad   = 0;
  int expInstret = 0;

  // Control vector order: pcWrite adrSrc memWrite irWrite regWrite resultSrc aluSrcA aluSrcB aluOp illegal
  logic [13:0] obsVec;
  assign obsVec = {pcWrite, adrSrc, memWrite, irWrite, regWrite,
                   resultSrc, aluSrcA, aluSrcB, aluOp, illegal};

  localparam logic [13:0] V_FETCH    = 14'b1_0_0_1_0_10_00_10_00_0;
  localparam logic [13:0] V_FETCHRST = 14'b0_0_0_0_0_10_00_10_00_0;
  localparam logic [13:0] V_DECODE   = 14'b0_0_0_0_0_00_01_01_00_0;
  localparam logic [13:0] V_DECILL   = 14'b0_0_0_0_0_00_01_01_00_1;
  localparam logic [13:0] V_MEMADR   = 14'b0_0_0_0_0_00_10_01_00_0;
  localparam logic [13:0] V_MEMREAD  = 14'b0_1_0_0_0_00_00_00_00_0;
  localparam logic [13:0] V_MEMWB    = 14'b0_0_0_0_1_01_00_00_00_0;
  localparam logic [13:0] V_MEMWRITE = 14'b0_1_1_0_0_00_00_00_00_0;
  localparam logic [13:0] V_EXECR    = 14'b0_0_0_0_0_00_10_00_10_0;
  localparam logic [13:0] V_EXECI    = 14'b0_0_0_0_0_00_10_01_00_0;
  localparam logic [13:0] V_ALUWB    = 14'b0_0_0_0_1_00_00_00_00_0;
  localparam logic [13:0] V_JAL      = 14'b1_0_0_0_0_00_01_10_00_0;
  localparam logic [13:0] V_BEQ0     = 14'b0_0_0_0_0_00_10_00_01_0;
  localparam logic [13:0] V_BEQ1     = 14'b1_0_0_0_0_00_10_00_01_0;
  localparam logic [13:0] V_FETCHW   = 14'b0_0_0_0_0_10_00_10_00_0;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    .memReady  (memReady),
`endif
    .op        (op),
    .zero      (zero),
    .pcWrite   (pcWrite),
    .adrSrc    (adrSrc),
    .memWrite  (memWrite),
    .irWrite   (irWrite),
    .regWrite  (regWrite),
    .resultSrc (resultSrc),
    .aluSrcA   (aluSrcA),
    .aluSrcB   (aluSrcB),
    .aluOp     (aluOp),
    .immSrc    (immSrc),
    .illegal   (illegal),
    .instret   (instret)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the opcode/zero inputs and let the combinational outputs settle.
  task automatic applyStimulus(input logic [6:0] opIn, input logic zeroIn);
    op   = opIn;
    zero = zeroIn;
    #1;
  endtask

  // Compare the control vector against the expected per-state value.
  task automatic checkOutput(input string tag, input logic [13:0] expVec);
    total++;
    assert (obsVec === expVec) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obsVec, expVec);
    end
  endtask

  task automatic checkInstret(input string tag);
    total++;
    assert (instret === 32'(expInstret)) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, instret, 32'(expInstret));
    end
  endtask

  task automatic checkImm(input string tag, input logic [1:0] expImm);
    total++;
    assert (immSrc === expImm) else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, immSrc, expImm);
    end
  endtask

  // Linear directed sequence; each instruction begins in a FETCH cycle.
  initial begin
    reset = 1'b1;
    op    = 7'b0000000;
    zero  = 1'b0;
    tick();
    tick();
    checkOutput("reset_outputs", V_FETCHRST);
    checkInstret("reset_instret");
    reset = 1'b0;
    #1;

    // lw with op changed during MEMREAD, which must not matter
    applyStimulus(7'b0000011, 1'b0);
    checkOutput("lw_c1_fetch", V_FETCH);
    tick(); checkOutput("lw_c2_decode", V_DECODE);
    tick(); checkOutput("lw_c3_memadr", V_MEMADR);
    tick(); applyStimulus(7'b0110011, 1'b0);
    checkOutput("lw_c4_memread", V_MEMREAD);
    tick(); checkOutput("lw_c5_memwb", V_MEMWB);
    checkInstret("lw_instret_before_retire");
    tick(); expInstret = 1;
    checkOutput("lw_next_fetch", V_FETCH);
    checkInstret("lw_instret");

    // beq taken
    applyStimulus(7'b1100011, 1'b1);
    checkImm("beq_imm", 2'b10);
    tick(); checkOutput("beqz1_decode", V_DECODE);
    tick(); checkOutput("beqz1_beq", V_BEQ1);
    tick(); expInstret = 2;
    checkOutput("beqz1_fetch", V_FETCH);
    checkInstret("beqz1_instret");

    // beq not taken
    applyStimulus(7'b1100011, 1'b0);
    tick(); tick(); checkOutput("beqz0_beq", V_BEQ0);
    tick(); expInstret = 3;
    checkOutput("beqz0_fetch", V_FETCH);
    checkInstret("beqz0_instret");

    // sw
    applyStimulus(7'b0100011, 1'b0);
    checkImm("sw_imm_c1", 2'b01);
    tick(); checkOutput("sw_c2_decode", V_DECODE); checkImm("sw_imm_c2", 2'b01);
    tick(); checkOutput("sw_c3_memadr", V_MEMADR); checkImm("sw_imm_c3", 2'b01);
    tick(); checkOutput("sw_c4_memwrite", V_MEMWRITE); checkImm("sw_imm_c4", 2'b01);
    tick(); expInstret = 4;
    checkOutput("sw_fetch", V_FETCH);
    checkInstret("sw_instret");

    // illegal opcode
    applyStimulus(7'b1111111, 1'b0);
    tick(); checkOutput("ill_c2_decode", V_DECILL);
    tick(); checkOutput("ill_c3_fetch", V_FETCH);
    checkInstret("ill_instret");

    // addi
    applyStimulus(7'b0010011, 1'b0);
    tick(); checkOutput("addi_decode", V_DECODE);
    tick(); checkOutput("addi_execi", V_EXECI);
    tick(); checkOutput("addi_aluwb", V_ALUWB);
    tick(); expInstret = 5;
    checkOutput("addi_fetch", V_FETCH);
    checkInstret("addi_instret");

    // jal
    applyStimulus(7'b1101111, 1'b0);
    checkImm("jal_imm", 2'b11);
    tick(); tick(); checkOutput("jal_jal", V_JAL);
    tick(); checkOutput("jal_aluwb", V_ALUWB);
    tick(); expInstret = 6;
    checkOutput("jal_fetch", V_FETCH);
    checkInstret("jal_instret");

    // reset in the middle of a load
    applyStimulus(7'b0000011, 1'b0);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    checkOutput("rst_memread_held", V_MEMREAD);
    tick(); expInstret = 0;
    checkOutput("rst_to_fetch", V_FETCHRST);
    checkInstret("rst_instret");
    reset = 1'b0;
    #1;
    checkOutput("rst_first_fetch", V_FETCH);
    tick(); checkOutput("rst_then_decode", V_DECODE);
    tick(); tick(); tick(); checkOutput("rst_lw_memwb", V_MEMWB);
    tick(); expInstret = 1;
    checkInstret("rst_lw_instret");

    // R-type retiring on a preloaded all-ones counter
    applyStimulus(7'b0110011, 1'b0);
    tick(); checkOutput("r_decode", V_DECODE);
    tick(); checkOutput("r_execr", V_EXECR);
    force dut.instret_q = 32'hFFFF_FFFF;
    tick(); release dut.instret_q;
    #1;
    expInstret = 32'hFFFF_FFFF;
    checkOutput("r_aluwb", V_ALUWB);
    checkInstret("wrap_preload");
    tick(); expInstret = 0;
    checkOutput("r_fetch", V_FETCH);
    checkInstret("wrap_instret");

`ifdef MULTICYCLE_CTRL_MEMWAIT_EN
    begin
      int irPulses = 0;
      int cycles   = 0;
      applyStimulus(7'b0000011, 1'b0);
      memReady = 1'b0;
      #1;
      checkOutput("wait_fetch_stall", V_FETCHW);
      for (int i = 0; i < 8; i++) begin
        if (i == 3) begin
          memReady = 1'b1;
          #1;
        end
        if (irWrite) irPulses++;
        tick();
        cycles++;
        if (obsVec === V_FETCH) break;
      end
      expInstret = 1;
      total++;
      assert (irPulses == 1) else begin
        bad++;
        $error("[TB] FAIL wait_ir_pulses observed=%0d expected=1", irPulses);
      end
      total++;
      assert (cycles == 8) else begin
        bad++;
        $error("[TB] FAIL wait_lw_latency observed=%0d expected=8", cycles);
      end
      checkInstret("wait_instret");
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-002 SHALL have these ports:
- op  input  7  instruction opcode from the instruction register.
- zero  input  1  ALU zero flag.
- pcWrite  output  1  PC register enable.
- adrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- memWrite  output  1  data memory write enable.
- irWrite  output  1  instruction register enable.
- regWrite  output  1  register file write enable.
- resultSrc  output  2  result select: 00 = ALUOut, 01 = memory data, 10 = ALU result.
- aluSrcA  output  2  ALU A select: 00 = PC, 01 = oldPC, 10 = rs1.
- aluSrcB  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- aluOp  output  2  00 = add, 01 = subtract (beq), 10 = funct-decoded.
- immSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- illegal  output  1  one-cycle pulse on an unknown opcode.
- instret  output  32  retired-instruction counter.

Function
REQ-003 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, BEQ.
REQ-004 SHALL use these transitions; any state not listed goes to FETCH:
- FETCH -> DECODE.
- DECODE -> MEMADR when op is 0000011 or 0100011.
- DECODE -> EXECR when op is 0110011.
- DECODE -> EXECI when op is 0010011.
- DECODE -> JAL when op is 1101111.
- DECODE -> BEQ when op is 1100011.
- DECODE -> FETCH for any other opcode.
- MEMADR -> MEMREAD when op is 0000011; otherwise MEMADR -> MEMWRITE.
- MEMREAD -> MEMWB.
- EXECR, EXECI and JAL -> ALUWB.
REQ-005 SHALL drive these per-state outputs; every output not listed is 0 (resultSrc, aluSrcA, aluSrcB and aluOp default to 00):
- FETCH: irWrite=1, aluSrcA=00, aluSrcB=10, resultSrc=10, pcUpdate=1.
- DECODE: aluSrcA=01, aluSrcB=01.
- MEMADR: aluSrcA=10, aluSrcB=01.
- MEMREAD: adrSrc=1.
- MEMWB: resultSrc=01, regWrite=1.
- MEMWRITE: adrSrc=1, memWrite=1.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp=10.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp=00.
- ALUWB: regWrite=1.
- JAL: aluSrcA=01, aluSrcB=10, pcUpdate=1.
- BEQ: aluSrcA=10, aluSrcB=00, aluOp=01, branch=1.
REQ-006 SHALL compute pcWrite = pcUpdate OR (branch AND zero), combinationally within the cycle.
REQ-007 SHALL decode immSrc combinationally from op in every state:
- 0100011 -> 01.
- 1100011 -> 10.
- 1101111 -> 11.
- all other opcodes -> 00.
REQ-008 SHALL take these cycle counts from FETCH entry to the next FETCH entry: lw 5, sw 4, R-type 4, addi 4, jal 4, beq 3, illegal opcode 2.
REQ-009 SHALL assert illegal for exactly the single DECODE cycle in which op is unknown, with no write enable asserted during that instruction except the FETCH-cycle pcWrite and irWrite.
REQ-010 SHALL increment instret by 1 on each clock edge that leaves MEMWB, MEMWRITE, ALUWB or BEQ, and not for illegal opcodes.
REQ-011 SHALL wrap instret from 0xFFFFFFFF to 0x00000000.
REQ-012 SHALL sample op only in DECODE and MEMADR; op changes in any other state SHALL NOT alter sequencing.

Reset
REQ-013 SHALL, on a clock edge with reset=1, set the state to FETCH and instret to 0, regardless of the current state (including mid-instruction).
REQ-014 SHALL force pcWrite, memWrite, irWrite, regWrite and illegal to 0 while reset=1.
REQ-015 SHALL make the first cycle after reset deasserts a normal FETCH cycle.

Configuration
REQ-016 SHALL, when MULTICYCLE_CTRL_MEMWAIT_EN is defined, add input memReady (1 bit, active-high), which behaves as follows:
- FETCH, MEMREAD and MEMWRITE hold their state while memReady=0.
- irWrite and pcUpdate in FETCH assert only in the cycle memReady=1.
- memWrite stays asserted throughout MEMWRITE.
- regWrite is never asserted during a wait.
REQ-017 SHALL, when MULTICYCLE_CTRL_MEMWAIT_EN is undefined, have no memReady port and no wait behaviour, with every state lasting exactly one cycle.

Verification
REQ-018 SHALL verify these directed scenarios:
- Reset, then op=0000011 held -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; regWrite=1 and resultSrc=01 only in cycle 5; instret=1 after cycle 5.
- op=1100011 with zero=1 -> pcWrite=1 in the BEQ cycle (cycle 3); with zero=0 -> pcWrite=0 in BEQ; instret increments in both cases.
- op=0100011 -> memWrite=1 only in cycle 4 with adrSrc=1; immSrc=01 throughout.
- op=1111111 -> illegal=1 in cycle 2, no regWrite or memWrite, back to FETCH in cycle 3, instret unchanged.
- Reset asserted during MEMREAD -> next state FETCH, instret=0, no regWrite pulse.
- With instret preloaded to 0xFFFFFFFF by retiring instructions (or forced), one R-type instruction -> instret=0; with MULTICYCLE_CTRL_MEMWAIT_EN and memReady=0 for 3 cycles in FETCH -> irWrite is a single pulse and the lw latency becomes 8.
